// File: rtl/nv_apb2csb_np_bridge.sv
// nv_apb2csb_np_bridge
//   APB slave to NVDLA CSB master bridge in the single pclk domain.
//   Each APB access becomes one CSB request.
//   Writes can be posted or non-posted; non-posted writes wait for nvdla2csb_wr_complete.
//   Misaligned byte addresses and CSB timeouts are answered with pslverr.
//   err_cnt is a saturating count of error responses.
//
// Ports
//   pclk, prstn                     clock, asynchronous active-low reset
//   psel, penable, pwrite,
//   paddr, pwdata                   APB request
//   prdata, pready, pslverr         APB response (pready is a single-cycle strobe)
//   csb2nvdla_valid/ready           CSB request handshake
//   csb2nvdla_addr/wdat/write/
//   nposted                         CSB request payload (word address = paddr[CSB_AW+1:2])
//   nvdla2csb_valid, nvdla2csb_data read response from the core
//   nvdla2csb_wr_complete           completion of a non-posted write
//   err_cnt                         saturating error-response counter
module nv_apb2csb_np_bridge #(
   parameter int APB_AW     = 32,
   parameter int CSB_AW     = 16,
   parameter int DW         = 32,
   parameter bit NPOSTED_WR = 1'b1,
   parameter int TIMEOUT    = 1023
) (
   input  logic              pclk,
   input  logic              prstn,
   input  logic              psel,
   input  logic              penable,
   input  logic              pwrite,
   input  logic [APB_AW-1:0] paddr,
   input  logic [DW-1:0]     pwdata,
   output logic [DW-1:0]     prdata,
   output logic              pready,
   output logic              pslverr,
   output logic              csb2nvdla_valid,
   input  logic              csb2nvdla_ready,
   output logic [CSB_AW-1:0] csb2nvdla_addr,
   output logic [DW-1:0]     csb2nvdla_wdat,
   output logic              csb2nvdla_write,
   output logic              csb2nvdla_nposted,
   input  logic              nvdla2csb_valid,
   input  logic [DW-1:0]     nvdla2csb_data,
   input  logic              nvdla2csb_wr_complete,
   output logic [7:0]        err_cnt
);

   typedef enum logic [2:0] {IDLE, REQ, WAIT_RD, WAIT_WR, RESP} state_t;

   localparam bit          TO_EN   = (TIMEOUT > 0);
   // The counter never needs to hold more than TIMEOUT-1.
   localparam int          TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TO_LAST = TW'(TO_EN ? TIMEOUT - 1 : 0);

   state_t              state_reg, state_next;
   logic [CSB_AW-1:0]   addr_reg, addr_next;
   logic [DW-1:0]       wdat_reg, wdat_next;
   logic                write_reg, write_next;
   logic                err_reg, err_next;
   logic [DW-1:0]       prdata_reg, prdata_next;
   logic                stale_rd_reg, stale_rd_next;
   logic                stale_wr_reg, stale_wr_next;
   logic [TW-1:0]       tcnt_reg, tcnt_next;
   logic                armed_reg, armed_next;
   logic [7:0]          err_cnt_reg, err_cnt_next;

   logic rd_hit, wr_hit, timeout_hit, in_flight;

   // Upper APB address bits do not reach the CSB word address.
   generate
      if (APB_AW > CSB_AW + 2) begin : g_hi_addr
         logic unused_hi_addr;
         assign unused_hi_addr = ^paddr[APB_AW-1:CSB_AW+2];
      end
   endgenerate

   always_ff @(posedge pclk or negedge prstn) begin
      if (!prstn) begin
         state_reg    <= IDLE;
         addr_reg     <= '0;
         wdat_reg     <= '0;
         write_reg    <= 1'b0;
         err_reg      <= 1'b0;
         prdata_reg   <= '0;
         stale_rd_reg <= 1'b0;
         stale_wr_reg <= 1'b0;
         tcnt_reg     <= '0;
         armed_reg    <= 1'b0;
         err_cnt_reg  <= '0;
      end else begin
         state_reg    <= state_next;
         addr_reg     <= addr_next;
         wdat_reg     <= wdat_next;
         write_reg    <= write_next;
         err_reg      <= err_next;
         prdata_reg   <= prdata_next;
         stale_rd_reg <= stale_rd_next;
         stale_wr_reg <= stale_wr_next;
         tcnt_reg     <= tcnt_next;
         armed_reg    <= armed_next;
         err_cnt_reg  <= err_cnt_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      addr_next     = addr_reg;
      wdat_next     = wdat_reg;
      write_next    = write_reg;
      err_next      = err_reg;
      prdata_next   = prdata_reg;
      stale_rd_next = stale_rd_reg;
      stale_wr_next = stale_wr_reg;
      tcnt_next     = tcnt_reg;
      armed_next    = armed_reg;
      err_cnt_next  = err_cnt_reg;

      // A pulse owed to an abandoned transfer is swallowed here, whatever the state.
      rd_hit = nvdla2csb_valid & ~stale_rd_reg;
      wr_hit = nvdla2csb_wr_complete & ~stale_wr_reg;
      if (nvdla2csb_valid && stale_rd_reg)       stale_rd_next = 1'b0;
      if (nvdla2csb_wr_complete && stale_wr_reg) stale_wr_next = 1'b0;

      // armed_reg is low in the first REQ cycle, so the count seen in
      // cycle k after REQ entry is k-1.  The timeout therefore fires in
      // cycle TIMEOUT, and the error response follows one cycle later.
      in_flight   = (state_reg == REQ) || (state_reg == WAIT_RD) || (state_reg == WAIT_WR);
      timeout_hit = TO_EN && armed_reg && (tcnt_reg == TO_LAST);
      if (in_flight) begin
         armed_next = 1'b1;
         if (armed_reg && TO_EN) tcnt_next = tcnt_reg + 1'b1;
      end else begin
         armed_next = 1'b0;
         tcnt_next  = '0;
      end

      case (state_reg)
         IDLE: begin
            if (psel && penable) begin
               addr_next  = paddr[CSB_AW+1:2];
               wdat_next  = pwdata;
               write_next = pwrite;
               if (paddr[1:0] != 2'b00) begin
                  err_next   = 1'b1;
                  state_next = RESP;
                  if (pwrite) prdata_next = '0;
               end else begin
                  state_next = REQ;
               end
            end
         end
         REQ: begin
            if (csb2nvdla_ready && !write_reg && rd_hit) begin
               prdata_next = nvdla2csb_data;
               state_next  = RESP;
            end else if (csb2nvdla_ready && write_reg && (!NPOSTED_WR || wr_hit)) begin
               prdata_next = '0;
               state_next  = RESP;
            end else if (timeout_hit) begin
               // An accepted request still owes a response; remember to drop it.
               err_next    = 1'b1;
               prdata_next = '0;
               state_next  = RESP;
               if (csb2nvdla_ready && !write_reg) stale_rd_next = 1'b1;
               if (csb2nvdla_ready && write_reg)  stale_wr_next = 1'b1;
            end else if (csb2nvdla_ready) begin
               state_next = write_reg ? WAIT_WR : WAIT_RD;
            end
         end
         WAIT_RD: begin
            if (rd_hit) begin
               prdata_next = nvdla2csb_data;
               state_next  = RESP;
            end else if (timeout_hit) begin
               err_next      = 1'b1;
               prdata_next   = '0;
               stale_rd_next = 1'b1;
               state_next    = RESP;
            end
         end
         WAIT_WR: begin
            if (wr_hit) begin
               prdata_next = '0;
               state_next  = RESP;
            end else if (timeout_hit) begin
               err_next      = 1'b1;
               prdata_next   = '0;
               stale_wr_next = 1'b1;
               state_next    = RESP;
            end
         end
         RESP: begin
            state_next = IDLE;
            err_next   = 1'b0;
            if (err_reg && (err_cnt_reg != 8'hFF)) err_cnt_next = err_cnt_reg + 8'd1;
         end
         default: state_next = IDLE;
      endcase
   end

   assign prdata            = prdata_reg;
   assign pready            = (state_reg == RESP);
   assign pslverr           = (state_reg == RESP) & err_reg;
   assign csb2nvdla_valid   = (state_reg == REQ);
   assign csb2nvdla_addr    = addr_reg;
   assign csb2nvdla_wdat    = wdat_reg;
   assign csb2nvdla_write   = write_reg;
   assign csb2nvdla_nposted = write_reg & NPOSTED_WR;
   assign err_cnt           = err_cnt_reg;

endmodule

// File: tb/tb_nv_apb2csb_np_bridge.sv
// Bench for nv_apb2csb_np_bridge.  Two instances: index 0 with posted
// writes, index 1 with non-posted writes, both with TIMEOUT=8.  The bench
// plays APB master and a reactive CSB slave whose stall and response
// delays come from each transaction record.
module tb_nv_apb2csb_np_bridge;

   typedef struct {
      int          d;          // instance index
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;      // data the slave returns for a read
      int          r;          // stall cycles before csb2nvdla_ready
      int          v;          // cycles from accept to completion, -1 = never
      bit          junk;       // also send a 0xDEAD read pulse on accept
      int          exp_lat;    // pready cycle, access sampled in cycle 0
      bit          exp_err;
      logic [31:0] exp_prdata;
      logic [15:0] exp_addr;
      bit          exp_np;
   } vec_t;

   logic        pclk;
   logic        prstn_a   [2];
   logic        psel_a    [2];
   logic        penable_a [2];
   logic        pwrite_a  [2];
   logic [31:0] paddr_a   [2];
   logic [31:0] pwdata_a  [2];
   logic [31:0] prdata_a  [2];
   logic        pready_a  [2];
   logic        pslverr_a [2];
   logic        cvalid_a  [2];
   logic        cready_a  [2];
   logic [15:0] caddr_a   [2];
   logic [31:0] cwdat_a   [2];
   logic        cwrite_a  [2];
   logic        cnp_a     [2];
   logic        rvalid_a  [2];
   logic [31:0] rdata_a   [2];
   logic        wcpl_a    [2];
   logic [7:0]  errcnt_a  [2];

   int          n_cmp = 0;
   int          n_bad = 0;
   int          txn   = 0;
   int          err_model   [2];
   logic [31:0] last_prdata [2];
   vec_t        vecs [9];

   nv_apb2csb_np_bridge #(.APB_AW(32), .CSB_AW(16), .DW(32), .NPOSTED_WR(1'b0), .TIMEOUT(8)) u_post (
      .pclk(pclk), .prstn(prstn_a[0]),
      .psel(psel_a[0]), .penable(penable_a[0]), .pwrite(pwrite_a[0]),
      .paddr(paddr_a[0]), .pwdata(pwdata_a[0]),
      .prdata(prdata_a[0]), .pready(pready_a[0]), .pslverr(pslverr_a[0]),
      .csb2nvdla_valid(cvalid_a[0]), .csb2nvdla_ready(cready_a[0]),
      .csb2nvdla_addr(caddr_a[0]), .csb2nvdla_wdat(cwdat_a[0]),
      .csb2nvdla_write(cwrite_a[0]), .csb2nvdla_nposted(cnp_a[0]),
      .nvdla2csb_valid(rvalid_a[0]), .nvdla2csb_data(rdata_a[0]),
      .nvdla2csb_wr_complete(wcpl_a[0]), .err_cnt(errcnt_a[0]));

   nv_apb2csb_np_bridge #(.APB_AW(32), .CSB_AW(16), .DW(32), .NPOSTED_WR(1'b1), .TIMEOUT(8)) u_np (
      .pclk(pclk), .prstn(prstn_a[1]),
      .psel(psel_a[1]), .penable(penable_a[1]), .pwrite(pwrite_a[1]),
      .paddr(paddr_a[1]), .pwdata(pwdata_a[1]),
      .prdata(prdata_a[1]), .pready(pready_a[1]), .pslverr(pslverr_a[1]),
      .csb2nvdla_valid(cvalid_a[1]), .csb2nvdla_ready(cready_a[1]),
      .csb2nvdla_addr(caddr_a[1]), .csb2nvdla_wdat(cwdat_a[1]),
      .csb2nvdla_write(cwrite_a[1]), .csb2nvdla_nposted(cnp_a[1]),
      .nvdla2csb_valid(rvalid_a[1]), .nvdla2csb_data(rdata_a[1]),
      .nvdla2csb_wr_complete(wcpl_a[1]), .err_cnt(errcnt_a[1]));

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s (txn %0d): got 0x%0h, required 0x%0h", name, txn, got, exp);
      end
   endfunction

   function automatic vec_t mk(input int d, input bit wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] rdata,
                               input int r, input int v, input bit junk,
                               input int exp_lat, input bit exp_err,
                               input logic [31:0] exp_prdata, input logic [15:0] exp_addr,
                               input bit exp_np);
      vec_t t;
      t.d = d; t.wr = wr; t.addr = addr; t.wdata = wdata; t.rdata = rdata;
      t.r = r; t.v = v; t.junk = junk; t.exp_lat = exp_lat; t.exp_err = exp_err;
      t.exp_prdata = exp_prdata; t.exp_addr = exp_addr; t.exp_np = exp_np;
      return t;
   endfunction

   // Reference model: latency and response follow directly from the
   // transaction's own delays and the documented rules.
   function automatic vec_t model(input int d, input bit wr, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [31:0] rdata,
                                  input int r, input int v);
      vec_t t;
      bit   posted;
      posted = wr && (d == 0);
      t = mk(d, wr, addr, wdata, rdata, r, v, 1'b0, 0, 1'b0, 32'h0, addr[17:2], wr && (d == 1));
      if (addr[1:0] != 2'b00) begin
         t.exp_lat    = 1;
         t.exp_err    = 1'b1;
         t.exp_prdata = wr ? 32'h0 : last_prdata[d];
      end else begin
         t.exp_lat    = 2 + r + (posted ? 0 : v);
         t.exp_prdata = wr ? 32'h0 : rdata;
      end
      return t;
   endfunction

   task automatic drive_rsp(input vec_t t);
      if (!t.wr) begin
         rvalid_a[t.d] = 1'b1;
         rdata_a[t.d]  = t.rdata;
      end else begin
         wcpl_a[t.d] = 1'b1;
      end
   endtask

   task automatic xfer(input vec_t t);
      int          di, n, stall, since, lat;
      bit          done, accepted, saw_valid, need_rsp, aligned, got_err, got_np, got_wr;
      logic [31:0] got_rd, got_wdat;
      logic [15:0] got_addr;
      di = t.d;
      n = 0; stall = 0; since = 0; lat = 0;
      done = 1'b0; accepted = 1'b0; saw_valid = 1'b0; got_err = 1'b0;
      got_np = 1'b0; got_wr = 1'b0; got_rd = '0; got_wdat = '0; got_addr = '0;
      aligned  = (t.addr[1:0] == 2'b00);
      need_rsp = !t.wr || (di == 1);
      txn++;
      @(negedge pclk);
      psel_a[di] = 1'b1; penable_a[di] = 1'b0; pwrite_a[di] = t.wr;
      paddr_a[di] = t.addr; pwdata_a[di] = t.wdata;
      @(negedge pclk);
      penable_a[di] = 1'b1;
      while (!done && n < 40) begin
         @(negedge pclk);
         n++;
         cready_a[di] = 1'b0; rvalid_a[di] = 1'b0; wcpl_a[di] = 1'b0;
         if (pready_a[di]) begin
            done = 1'b1; lat = n;
            got_rd = prdata_a[di]; got_err = pslverr_a[di];
            psel_a[di] = 1'b0; penable_a[di] = 1'b0;
         end else if (cvalid_a[di]) begin
            if (!saw_valid) begin
               got_addr = caddr_a[di]; got_np = cnp_a[di];
               got_wr = cwrite_a[di]; got_wdat = cwdat_a[di];
            end
            saw_valid = 1'b1;
            if (stall == t.r) begin
               cready_a[di] = 1'b1; accepted = 1'b1; since = 0;
               if (need_rsp && t.junk) begin
                  rvalid_a[di] = 1'b1;
                  rdata_a[di]  = 32'h0000_DEAD;
               end else if (need_rsp && t.v == 0) begin
                  drive_rsp(t);
               end
            end else begin
               stall++;
            end
         end else if (accepted && need_rsp) begin
            since++;
            if (since == t.v) drive_rsp(t);
         end
      end
      if (!done) begin
         n_cmp++; n_bad++;
         $display("FAIL no_pready (txn %0d): got none in 40 cycles, required pready at cycle %0d", txn, t.exp_lat);
         psel_a[di] = 1'b0; penable_a[di] = 1'b0;
      end else begin
         chk("latency", 32'(lat), 32'(t.exp_lat));
         chk("pslverr", {31'b0, got_err}, {31'b0, t.exp_err});
         chk("prdata", got_rd, t.exp_prdata);
      end
      @(negedge pclk);
      cready_a[di] = 1'b0; rvalid_a[di] = 1'b0; wcpl_a[di] = 1'b0;
      chk("pready_single", {31'b0, pready_a[di]}, 32'h0);
      if (t.exp_err && err_model[di] < 255) err_model[di]++;
      chk("err_cnt", {24'b0, errcnt_a[di]}, 32'(err_model[di]));
      if (aligned) begin
         chk("csb_seen", {31'b0, saw_valid}, 32'h1);
         if (saw_valid) begin
            chk("csb_addr", {16'b0, got_addr}, {16'b0, t.exp_addr});
            chk("csb_nposted", {31'b0, got_np}, {31'b0, t.exp_np});
            chk("csb_write", {31'b0, got_wr}, {31'b0, t.wr});
            if (t.wr) chk("csb_wdat", got_wdat, t.wdata);
         end
      end else begin
         chk("csb_seen", {31'b0, saw_valid}, 32'h0);
      end
      last_prdata[di] = t.exp_prdata;
      $display("txn %0d dut%0d %s addr=0x%08h lat=%0d prdata=0x%08h err=%0b err_cnt=%0d",
               txn, di, t.wr ? "WR" : "RD", t.addr, lat, got_rd, got_err, errcnt_a[di]);
   endtask

   task automatic check_all_zero(input int d, input string tag);
      chk({tag, "_prdata"},  prdata_a[d], 32'h0);
      chk({tag, "_pready"},  {31'b0, pready_a[d]}, 32'h0);
      chk({tag, "_pslverr"}, {31'b0, pslverr_a[d]}, 32'h0);
      chk({tag, "_cvalid"},  {31'b0, cvalid_a[d]}, 32'h0);
      chk({tag, "_caddr"},   {16'b0, caddr_a[d]}, 32'h0);
      chk({tag, "_cwdat"},   cwdat_a[d], 32'h0);
      chk({tag, "_cwrite"},  {31'b0, cwrite_a[d]}, 32'h0);
      chk({tag, "_cnp"},     {31'b0, cnp_a[d]}, 32'h0);
      chk({tag, "_err_cnt"}, {24'b0, errcnt_a[d]}, 32'h0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      for (int d = 0; d < 2; d++) begin
         prstn_a[d] = 1'b0; psel_a[d] = 1'b0; penable_a[d] = 1'b0; pwrite_a[d] = 1'b0;
         paddr_a[d] = '0; pwdata_a[d] = '0; cready_a[d] = 1'b0; rvalid_a[d] = 1'b0;
         rdata_a[d] = '0; wcpl_a[d] = 1'b0; err_model[d] = 0; last_prdata[d] = '0;
      end

      // Test-plan and boundary vectors.
      vecs[0] = mk(0, 1, 32'h0000_5004, 32'hA5A5_0001, 32'h0, 0, 0, 0, 2, 0, 32'h0, 16'h1401, 0);
      vecs[1] = mk(0, 0, 32'h0000_0010, 32'h0, 32'h1234_5678, 3, 2, 0, 7, 0, 32'h1234_5678, 16'h0004, 0);
      vecs[2] = mk(1, 1, 32'h0000_0020, 32'hCAFE_0002, 32'h0, 0, 5, 0, 7, 0, 32'h0, 16'h0008, 1);
      vecs[3] = mk(1, 0, 32'h0000_0006, 32'h0, 32'h0, 0, 0, 0, 1, 1, 32'h0, 16'h0001, 0);
      vecs[4] = mk(0, 0, 32'h4000_FFFC, 32'h0, 32'h89AB_CDEF, 0, 0, 0, 2, 0, 32'h89AB_CDEF, 16'h3FFF, 0);
      vecs[5] = mk(0, 0, 32'h0000_0003, 32'h0, 32'h0, 0, 0, 0, 1, 1, 32'h89AB_CDEF, 16'h0000, 0);
      vecs[6] = mk(0, 1, 32'h0000_0101, 32'h1111_2222, 32'h0, 0, 0, 0, 1, 1, 32'h0, 16'h0040, 0);
      vecs[7] = mk(1, 0, 32'h0001_FFFC, 32'h0, 32'h0BAD_F00D, 2, 0, 0, 4, 0, 32'h0BAD_F00D, 16'h7FFF, 0);
      vecs[8] = mk(1, 1, 32'h0000_0008, 32'h7777_8888, 32'h0, 1, 0, 0, 3, 0, 32'h0, 16'h0002, 1);

      repeat (3) @(negedge pclk);
      for (int d = 0; d < 2; d++) check_all_zero(d, "reset");
      prstn_a[0] = 1'b1; prstn_a[1] = 1'b1;
      repeat (2) @(negedge pclk);

      for (int i = 0; i < 9; i++) xfer(vecs[i]);

      // Read accepted but never answered: error at cycle 9 after REQ entry,
      // then the late 0xDEAD pulse must be dropped by the following read.
      xfer(mk(0, 0, 32'h0000_0040, 32'h0, 32'h0, 0, -1, 0, 10, 1, 32'h0, 16'h0010, 0));
      xfer(mk(0, 0, 32'h0000_0044, 32'h0, 32'h0000_0042, 1, 2, 1, 5, 0, 32'h0000_0042, 16'h0011, 0));
      // Write never accepted: request is abandoned by the timeout.
      xfer(mk(1, 1, 32'h0000_0050, 32'hFEED_BEEF, 32'h0, 100, 0, 0, 10, 1, 32'h0, 16'h0014, 1));
      xfer(mk(1, 0, 32'h0000_0054, 32'h0, 32'h0000_5151, 0, 1, 0, 3, 0, 32'h0000_5151, 16'h0015, 0));

      // Randomized traffic on both instances, delays kept below the timeout.
      for (int i = 0; i < 80; i++) begin
         int          d, r, v;
         bit          wr;
         logic [31:0] addr;
         d = int'($urandom_range(0, 1));
         wr = 1'($urandom_range(0, 1));
         addr = $urandom;
         if ($urandom_range(0, 7) != 0) addr[1:0] = 2'b00;
         else if (addr[1:0] == 2'b00) addr[1:0] = 2'b10;
         r = int'($urandom_range(0, 3));
         v = int'($urandom_range(0, 3));
         xfer(model(d, wr, addr, $urandom, $urandom, r, v));
         repeat ($urandom_range(0, 2)) @(negedge pclk);
      end

      // Drive the error counter into saturation.
      for (int i = 0; i < 260; i++)
         xfer(model(0, 1'b0, 32'h0000_1001, 32'h0, 32'h0, 0, 0));
      chk("err_cnt_saturated", {24'b0, errcnt_a[0]}, 32'd255);

      // Reset asserted while a read waits for its response.
      xfer(mk(1, 0, 32'h0000_0084, 32'h0, 32'h5555_AAAA, 0, 1, 0, 3, 0, 32'h5555_AAAA, 16'h0021, 0));
      txn++;
      @(negedge pclk);
      psel_a[1] = 1'b1; penable_a[1] = 1'b0; pwrite_a[1] = 1'b0; paddr_a[1] = 32'h0000_0088;
      @(negedge pclk);
      penable_a[1] = 1'b1;
      @(negedge pclk);
      chk("rst_req_valid", {31'b0, cvalid_a[1]}, 32'h1);
      cready_a[1] = 1'b1;
      @(negedge pclk);
      cready_a[1] = 1'b0;
      chk("rst_wait_rd", {31'b0, cvalid_a[1] | pready_a[1]}, 32'h0);
      #2 prstn_a[1] = 1'b0;
      #1 check_all_zero(1, "async_rst");
      psel_a[1] = 1'b0; penable_a[1] = 1'b0;
      $display("txn %0d dut1 RD addr=0x00000088 reset during WAIT_RD", txn);
      repeat (2) @(negedge pclk);
      prstn_a[1] = 1'b1;
      err_model[1] = 0;
      last_prdata[1] = '0;
      xfer(mk(1, 0, 32'h0000_008C, 32'h0, 32'h0000_0077, 1, 1, 0, 4, 0, 32'h0000_0077, 16'h0023, 0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
